// File: rtl/sram_responder.sv
// sram_responder: device side of a 16-bit SRAM bus with a READ_LAT-deep read pipeline.
// Define SRAM_RESP_STATS_EN to add the wr_cnt/rd_cnt access counters.
module sram_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  output logic              oor_err
`ifdef SRAM_RESP_STATS_EN
  ,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       rd_cnt
`endif
);

  localparam int WORDS = 1 << DEPTH_W;

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
      $error("sram_responder: READ_LAT must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0]  mem [WORDS];
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [DEPTH_W-1:0] addr_q [READ_LAT];
  logic [DEPTH_W-1:0] addr_d [READ_LAT];
  logic               oor_q, oor_d;
  logic [DEPTH_W-1:0] word_addr;
  logic               addr_hi;
  logic               dq_oe;

  assign word_addr = SRAM_ADDR[DEPTH_W-1:0];
  assign addr_hi   = |SRAM_ADDR[ADDR_W-1:DEPTH_W];

  // Stage 0 captures every cycle's access; a write enters as an invalid slot.
  always_comb begin
    vld_d[0]  = SRAM_WE_N;
    addr_d[0] = word_addr;
    for (int k = 1; k < READ_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      addr_d[k] = addr_q[k-1];
    end
    oor_d = oor_q | addr_hi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      oor_q <= 1'b0;
      for (int k = 0; k < READ_LAT; k++) addr_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      oor_q <= oor_d;
      for (int k = 0; k < READ_LAT; k++) addr_q[k] <= addr_d[k];
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (!SRAM_WE_N) mem[word_addr] <= SRAM_DQ;
  end

  // Reading the array at return time forwards any write that landed in flight,
  // and WE_N low releases the bus in the same cycle.
  assign dq_oe   = vld_q[READ_LAT-1] & SRAM_WE_N;
  assign SRAM_DQ = dq_oe ? mem[addr_q[READ_LAT-1]] : {DATA_W{1'bz}};
  assign oor_err = oor_q;

`ifdef SRAM_RESP_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (!SRAM_WE_N) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (dq_oe)      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule
